pc_seq: RTL
===========

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter PC_W, default 16, PC and datapath width in bits.
REQ-002 Parameter RESET_VEC, default 16'h3000, PC value loaded on reset.
REQ-003 Parameter AUTO_INC, default 1: 1 = PC+1 every unstalled cycle without load; 0 = PC holds without load.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, 2..16.
REQ-005 clk  in  1  clock, all state updated on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  freezes all state this cycle.
REQ-008 ld_pc  in  1  load PC from source chosen by pc_sel.
REQ-009 pc_sel  in  2  source: 0 INC, 1 OFFSET, 2 REG, 3 VECTOR.
REQ-010 offset  in  PC_W  pre-sign-extended PC-relative offset.
REQ-011 reg_val  in  PC_W  register-indirect target.
REQ-012 vec_addr  in  8  trap/interrupt vector number.
REQ-013 push  in  1  push return address (JSR/JSRR).
REQ-014 pop  in  1  pop return address (RET).
REQ-015 clr_flags  in  1  clears sticky flags.
REQ-016 pc  out  PC_W  current PC, registered.
REQ-017 pc_plus1  out  PC_W  registered, always equals pc+1 mod 2^PC_W.
REQ-018 ras_top  out  PC_W  top stack entry; 0 when empty.
REQ-019 ras_count  out  clog2(RAS_DEPTH+1)  occupied entries.
REQ-020 ras_ovf  out  1  sticky: push dropped an entry.
REQ-021 ras_unf  out  1  sticky: pop on empty stack.

Function
REQ-022 stall=1 SHALL hold pc, pc_plus1, stack and flags; push, pop, ld_pc and clr_flags ignored.
REQ-023 Unstalled, ld_pc=0: pc <= pc_plus1 when AUTO_INC=1, else hold.
REQ-024 Unstalled, ld_pc=1: pc <= INC: pc+1; OFFSET: pc+1+offset; REG: reg_val; VECTOR: zero-extended vec_addr.
REQ-025 All PC arithmetic modulo 2^PC_W; pc=all-ones with INC wraps to 0.
REQ-026 pc_plus1 SHALL be updated in the same cycle as pc, giving a new-PC-to-output latency of one cycle.
REQ-027 Unstalled push SHALL store pc+1 (pre-update PC plus one) as the new top.
REQ-028 Push when count=RAS_DEPTH SHALL overwrite the oldest entry (circular), keep count, set ras_ovf.
REQ-029 Unstalled pop with count>0 SHALL remove the top entry and decrement count; pop does not change pc.
REQ-030 Pop when count=0 SHALL set ras_unf; stack is unchanged.
REQ-031 Push and pop together SHALL replace the top in place, keeping count; on an empty stack this acts as a push and sets ras_unf.
REQ-032 clr_flags SHALL clear both flags; a flag event in the same cycle wins (flag set).
REQ-033 Stack operations are independent of ld_pc and pc_sel.

Reset
REQ-034 reset SHALL set pc=RESET_VEC, pc_plus1=RESET_VEC+1, ras_count=0, ras_top=0, ras_ovf=0, ras_unf=0 immediately and asynchronously.
REQ-035 reset during any operation SHALL abandon it; stack contents after reset are don't-care but unobservable.

Structure
REQ-036 Shared package lc3_pc_pkg SHALL hold the pc_sel encodings (PCSEL_INC, PCSEL_OFS, PCSEL_REG, PCSEL_VEC) and the default RESET_VEC.
REQ-037 The return stack SHALL be the sub-module pc_ras (storage, pointer, count, flags); next-PC selection stays in pc_seq.

Verification
REQ-038 Reset release, AUTO_INC=1, 3 cycles -> pc 3000, 3001, 3002, 3003; pc_plus1 always pc+1.
REQ-039 pc=3005, ld_pc, OFFSET, offset=FFFE -> pc=3004; next cycle REG reg_val=4000 -> pc=4000; VECTOR vec_addr=25 -> pc=0025.
REQ-040 pc=FFFF, no load -> pc=0000, pc_plus1=0001; stall held 3 cycles -> pc stays 0000.
REQ-041 Five pushes at pc=1000..1004, depth 4 -> count=4, ras_ovf=1, top=1005; four pops -> count=0; fifth pop -> ras_unf=1.
REQ-042 Push+pop at count=2 -> count stays 2, top replaced; clr_flags with simultaneous underflow -> ras_unf stays 1.
REQ-043 reset asserted mid-stream with count=3 -> outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/lc3_pc_pkg.sv
// Shared encodings for the PC sequencer slice:
// next-PC source select values and the default reset vector.
package lc3_pc_pkg;

  typedef enum logic [1:0] {
    PCSEL_INC = 2'd0,
    PCSEL_OFS = 2'd1,
    PCSEL_REG = 2'd2,
    PCSEL_VEC = 2'd3
  } pc_sel_e;

  localparam logic [15:0] DEF_RESET_VEC = 16'h3000;

endpackage

// File: rtl/pc_seq_if.sv
// Control/status bundle between the core and the PC sequencer.
// Master drives stall/load/select/stack controls; slave returns pc, pc_plus1 and stack status.
interface pc_seq_if
  import lc3_pc_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             ld_pc;
  pc_sel_e          pc_sel;
  logic [PC_W-1:0]  offset;
  logic [PC_W-1:0]  reg_val;
  logic [7:0]       vec_addr;
  logic             push;
  logic             pop;
  logic             clr_flags;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, ld_pc, pc_sel, offset, reg_val, vec_addr,
    output push, pop, clr_flags,
    input  pc, pc_plus1, ras_top, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, ld_pc, pc_sel, offset, reg_val, vec_addr,
    input  push, pop, clr_flags,
    output pc, pc_plus1, ras_top, ras_count, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack with count and sticky overflow/underflow flags.
// Ports: clk, reset, en, push, pop, clr_flags, din -> top, count, ovf, unf.
module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_flags,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          unf
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic          empty;
  logic          full;
  logic          wr_new;
  logic          wr_top;
  logic          rm;
  logic          ovf_evt;
  logic          unf_evt;
  logic [PW-1:0] wr_idx;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // push+pop on a non-empty stack rewrites the top in place;
  // on an empty stack it degrades to a plain push.
  always_comb begin
    wr_new  = en & push & (~pop | empty);
    wr_top  = en & push & pop & ~empty;
    rm      = en & pop & ~push & ~empty;
    ovf_evt = en & push & ~pop & full;
    unf_evt = en & pop & empty;
    wr_idx  = wr_top ? ptr : ptr + PW'(1);
  end

  // storage needs no reset: count gates visibility
  always_ff @(posedge clk) begin
    if (wr_new | wr_top)
      mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (en) begin
      if (wr_new) begin
        ptr <= ptr + PW'(1);
        if (!full)
          count <= count + CW'(1);
      end else if (rm) begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
      ovf <= (ovf & ~clr_flags) | ovf_evt;
      unf <= (unf & ~clr_flags) | unf_evt;
    end
  end

  assign top = empty ? '0 : mem[ptr];

endmodule

// File: rtl/pc_seq.sv
// Program counter sequencer with registered pc/pc_plus1 and a return stack.
// Ports: clk, reset (async, active-high), bus (pc_seq_if.slave).
module pc_seq
  import lc3_pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter bit              AUTO_INC  = 1'b1,
  parameter int              RAS_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  pc_seq_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc1_q;
  logic [PC_W-1:0]  pc_n;
  logic [PC_W-1:0]  top;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             unf;
  logic             en;

  assign en = ~bus.stall;

  // pc_plus1 is kept as a register so offset targets
  // only need one adder after the pc flop.
  always_comb begin
    pc_n = AUTO_INC ? pc1_q : pc_q;
    if (bus.ld_pc) begin
      unique case (bus.pc_sel)
        PCSEL_INC: pc_n = pc1_q;
        PCSEL_OFS: pc_n = pc1_q + bus.offset;
        PCSEL_REG: pc_n = bus.reg_val;
        PCSEL_VEC: pc_n = PC_W'(bus.vec_addr);
        default:   pc_n = pc1_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      pc1_q <= RESET_VEC + PC_W'(1);
    end else if (en) begin
      pc_q  <= pc_n;
      pc1_q <= pc_n + PC_W'(1);
    end
  end

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .push      (bus.push),
    .pop       (bus.pop),
    .clr_flags (bus.clr_flags),
    .din       (pc1_q),
    .top       (top),
    .count     (count),
    .ovf       (ovf),
    .unf       (unf)
  );

  assign bus.pc        = pc_q;
  assign bus.pc_plus1  = pc1_q;
  assign bus.ras_top   = top;
  assign bus.ras_count = count;
  assign bus.ras_ovf   = ovf;
  assign bus.ras_unf   = unf;

endmodule
